// File: rtl/s2p_frame_ctrl.sv
// Serial-to-parallel sequencer: assembles 2**N framed serial bits, pulses load_en once per word,
// then holds the word (sin_ready low) until out_valid && out_ready consumes it.
module s2p_frame_ctrl #(
  parameter int unsigned N         = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sin,
  input  logic              sin_valid,
  input  logic              sync,
  output logic              sin_ready,
  output logic [2**N-1:0]   par_data,
  output logic              load_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_err,
  output logic [7:0]        frame_cnt
);
  localparam int unsigned W = 2**N;
  localparam logic [N-1:0] CNT_ONE  = N'(1);
  localparam logic [N-1:0] CNT_LAST = N'(W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD, HOLD} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [W-1:0] shreg_q, shreg_d;
  logic [W-1:0] shreg_next, shreg_first;
  logic         frame_err_q, frame_err_d;
  logic [7:0]   frame_cnt_q, frame_cnt_d;
  logic         accept;

  assign sin_ready = (state_q == IDLE) || (state_q == SHIFT);
  assign accept    = sin_valid && sin_ready;
  assign par_data  = shreg_q;
  assign load_en   = (state_q == LOAD);
  assign out_valid = (state_q == HOLD);
  assign frame_err = frame_err_q;
  assign frame_cnt = frame_cnt_q;

  // A restarting frame begins from a cleared register so no stale bits survive.
  always_comb begin
    shreg_next  = shreg_q;
    shreg_first = '0;
    if (MSB_FIRST) begin
      shreg_next  = {shreg_q[W-2:0], sin};
      shreg_first = {{(W-1){1'b0}}, sin};
    end else begin
      shreg_next  = {sin, shreg_q[W-1:1]};
      shreg_first = {sin, {(W-1){1'b0}}};
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    frame_err_d = 1'b0;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept && sync) begin
          shreg_d = shreg_first;
          cnt_d   = CNT_ONE;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (accept && sync) begin
          shreg_d     = shreg_first;
          cnt_d       = CNT_ONE;
          frame_err_d = 1'b1;
        end else if (accept) begin
          shreg_d = shreg_next;
          cnt_d   = cnt_q + CNT_ONE;   // wraps to 0 on the final bit
          if (cnt_q == CNT_LAST) state_d = LOAD;
        end
      end
      LOAD: begin
        frame_cnt_d = frame_cnt_q + 8'd1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_s2p_frame_ctrl.sv
// Drives one framed bit stream into an MSB-first and an LSB-first instance and scores both
// against a queue-based frame model.
module tb_s2p_frame_ctrl;
  localparam int N = 4;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n, sin, sin_valid, sync, out_ready;
  logic sin_ready, load_en, out_valid, frame_err;
  logic [W-1:0] par_data;
  logic [7:0] frame_cnt;
  logic l_sin_ready, l_load_en, l_out_valid, l_frame_err;
  logic [W-1:0] l_par_data;
  logic [7:0] l_frame_cnt;

  s2p_frame_ctrl #(.N(N), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid), .sync(sync),
    .sin_ready(sin_ready), .par_data(par_data), .load_en(load_en), .out_valid(out_valid),
    .out_ready(out_ready), .frame_err(frame_err), .frame_cnt(frame_cnt));

  s2p_frame_ctrl #(.N(N), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid), .sync(sync),
    .sin_ready(l_sin_ready), .par_data(l_par_data), .load_en(l_load_en), .out_valid(l_out_valid),
    .out_ready(out_ready), .frame_err(l_frame_err), .frame_cnt(l_frame_cnt));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int neg_cnt = 0;
  int ready_mode = 1;

  // Scoreboard queues filled by the model, drained by the monitors.
  bit          frame[$];
  logic [W-1:0] exp_msb_q[$];
  logic [W-1:0] exp_lsb_q[$];
  int           exp_time_q[$];
  logic [7:0]   exp_cnt_q[$];
  int           err_time_q[$];
  logic [7:0]   exp_cnt;
  logic         consumed;

  logic [W-1:0] hold_word, wm, wl, w_exp;
  logic [7:0]   pend_c;
  logic         pend, prev_load;
  int           t_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Reference model: a frame is the list of bits since the last accepted sync.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame.delete();
      exp_cnt  = 8'd0;
      consumed = 1'b0;
    end else begin
      consumed = out_valid && out_ready;
      if (sin_valid && sin_ready) begin
        if (sync) begin
          if (frame.size() > 0) err_time_q.push_back(neg_cnt + 1);
          frame.delete();
          frame.push_back(sin);
        end else if (frame.size() > 0) begin
          frame.push_back(sin);
        end
        if (frame.size() == W) begin
          for (int i = 0; i < W; i++) begin
            wm[W-1-i] = frame[i];
            wl[i]     = frame[i];
          end
          exp_cnt = exp_cnt + 8'd1;
          exp_msb_q.push_back(wm);
          exp_lsb_q.push_back(wl);
          exp_time_q.push_back(neg_cnt + 1);
          exp_cnt_q.push_back(exp_cnt);
          frame.delete();
        end
      end
    end
  end

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      = 1'b0;
      prev_load = 1'b0;
    end else begin
      neg_cnt++;
      if (load_en) begin
        chk("load_len", {31'd0, prev_load}, 32'd0);
        chk("load_ready", {31'd0, sin_ready}, 32'd0);
        if (exp_msb_q.size() == 0) begin
          chk("spurious_load", 32'd1, 32'd0);
        end else begin
          w_exp = exp_msb_q.pop_front();
          t_exp = exp_time_q.pop_front();
          pend_c = exp_cnt_q.pop_front();
          chk("load_data", {16'd0, par_data}, {16'd0, w_exp});
          chk("load_latency", neg_cnt, t_exp);
          hold_word = w_exp;
          pend = 1'b1;
        end
      end else if (pend) begin
        chk("out_valid_rise", {31'd0, out_valid}, 32'd1);
        chk("frame_cnt", {24'd0, frame_cnt}, {24'd0, pend_c});
        pend = 1'b0;
      end
      if (out_valid) begin
        chk("hold_data", {16'd0, par_data}, {16'd0, hold_word});
        chk("hold_ready", {31'd0, sin_ready}, 32'd0);
      end
      if (consumed) begin
        chk("release_valid", {31'd0, out_valid}, 32'd0);
        chk("release_ready", {31'd0, sin_ready}, 32'd1);
      end
      if (frame_err) begin
        if (err_time_q.size() == 0) chk("spurious_frame_err", 32'd1, 32'd0);
        else chk("frame_err_time", neg_cnt, err_time_q.pop_front());
      end
      if (l_load_en) begin
        if (exp_lsb_q.size() == 0) chk("lsb_spurious_load", 32'd1, 32'd0);
        else chk("lsb_load_data", {16'd0, l_par_data}, {16'd0, exp_lsb_q.pop_front()});
      end
      prev_load = load_en;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input logic s);
    int w = 0;
    while (!sin_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!sin_ready) chk("ready_timeout", {31'd0, sin_ready}, 32'd1);
    sin = b; sync = s; sin_valid = 1'b1;
    @(negedge clk);
    sin_valid = 1'b0; sync = 1'b0; sin = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] wd, input int gap);
    for (int i = W - 1; i >= 0; i--) begin
      send_bit(wd[i], i == W - 1);
      if (gap > 0) idle(gap == 1 ? 1 : $urandom_range(0, 2));
    end
  endtask

  task automatic wait_valid();
    int w = 0;
    while (!out_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("valid_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic check_reset();
    chk("rst_par_data", {16'd0, par_data}, 32'd0);
    chk("rst_load_en", {31'd0, load_en}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
    chk("rst_sin_ready", {31'd0, sin_ready}, 32'd1);
    chk("rst_lsb_out_valid", {31'd0, l_out_valid}, 32'd0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; sin = 1'b0; sin_valid = 1'b0; sync = 1'b0;
    #22;
    check_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Back-to-back frame, then one with a gap on every other cycle and a stalled consumer.
    send_word(16'hA5C3, 0);
    idle(4);
    ready_mode = 0;
    send_word(16'hA5C3, 1);
    wait_valid();
    idle(10);
    ready_mode = 1;
    idle(3);

    // Partial frame aborted by a fresh sync.
    send_bit(1'b1, 1'b1);
    for (int i = 0; i < 6; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    send_word(16'h1234, 0);
    idle(4);

    // Unframed bits are ignored while idle.
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    send_word(16'hFFFF, 0);
    idle(4);

    // Reset mid-frame, then a clean frame.
    send_bit(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b0);
    pulse_reset();
    send_word(16'h0F0F, 0);
    idle(4);

    // Reset while a word is waiting for the consumer.
    ready_mode = 0;
    send_word(16'h5A5A, 0);
    wait_valid();
    idle(2);
    pulse_reset();
    ready_mode = 1;
    idle(2);

    // Random traffic: junk bits, aborted frames, gaps and random consumer readiness.
    ready_mode = 2;
    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(0, 3) == 0) send_bit(1'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        send_bit(1'($urandom_range(0, 1)), 1'b1);
        repeat ($urandom_range(0, 14)) send_bit(1'($urandom_range(0, 1)), 1'b0);
      end
      send_word(16'($urandom()), 2);
    end
    ready_mode = 1;
    idle(6);
    chk("cnt_model", {24'd0, frame_cnt}, {24'd0, exp_cnt});
    chk("lsb_cnt_model", {24'd0, l_frame_cnt}, {24'd0, exp_cnt});

    // Counter wrap: 256 frames of a single leading one.
    pulse_reset();
    for (int f = 0; f < 256; f++) send_word(16'h8000, 0);
    idle(6);
    chk("wrap_frame_cnt", {24'd0, frame_cnt}, 32'd0);
    chk("wrap_lsb_frame_cnt", {24'd0, l_frame_cnt}, 32'd0);
    chk("lsb_last_word", {16'd0, l_par_data}, 32'h0001);

    chk("pending_words", exp_msb_q.size(), 32'd0);
    chk("pending_lsb_words", exp_lsb_q.size(), 32'd0);
    chk("pending_frame_err", err_time_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/s2p_frame_ctrl.md
Name: s2p_frame_ctrl

Overview:
Sequencing controller for the 16-bit clock-enabled parallel register in the S2P path. Accepts a framed serial bit stream (valid/ready, with a frame-start marker) and assembles 2**N bits in an internal shift register. When a word is complete it pulses the register's enable for exactly one cycle. It then holds the word until a downstream consumer takes it. It also flags frames that are interrupted by a new frame start.

Parameters:
N, 4, log2 of word width; word width W = 2**N (default 16)
MSB_FIRST, 1, 1 = first serial bit lands in bit W-1; 0 = first serial bit lands in bit 0

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
sin  input  1  serial data bit
sin_valid  input  1  sin carries a bit this cycle
sync  input  1  qualified by sin_valid: this bit is the first bit of a frame
sin_ready  output  1  controller can accept a bit this cycle
par_data  output  W  shift-register contents; drives the parallel register data input
load_en  output  1  one-cycle enable pulse to the parallel register
out_valid  output  1  parallel register holds a complete, unconsumed word
out_ready  input  1  downstream consumes word when out_valid && out_ready
frame_err  output  1  one-cycle pulse: partial frame aborted by new sync
frame_cnt  output  8  count of words loaded, wraps 255 -> 0

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous assert, synchronous deassert at the system level.
- Reset values: state=IDLE, bit counter=0, shift register=0, par_data=0, load_en=0, out_valid=0, frame_err=0, frame_cnt=0. sin_ready=1 once out of reset.
- Accept rule: a bit is accepted when sin_valid && sin_ready at a rising edge.
- Shift rule:
  - MSB_FIRST=1: shreg <= {shreg[W-2:0], sin}.
  - MSB_FIRST=0: shreg <= {sin, shreg[W-1:1]}.
- States:
  - IDLE: sin_ready=1. Accepted bit with sync=1 is shifted in, cnt=1, next SHIFT. Accepted bit with sync=0 is dropped; state stays IDLE, no flag.
  - SHIFT: sin_ready=1.
    - Accepted bit with sync=0 is shifted in and cnt increments.
    - If that bit is bit W (cnt==W-1 before the edge), go to LOAD.
    - Accepted bit with sync=1 aborts the frame: frame_err=1 for the next cycle, the shift register restarts with this bit as first bit, cnt=1, state stays SHIFT.
    - No accepted bit: all state is held; gaps of any length are allowed.
  - LOAD: exactly one cycle. load_en=1, sin_ready=0, frame_cnt increments. Next state HOLD.
  - HOLD: out_valid=1, sin_ready=0. On out_ready=1, the next state is IDLE and out_valid drops the following cycle.
- Latency:
  - Last bit accepted at edge t: load_en is high in cycle t..t+1, and the register captures at edge t+1.
  - out_valid is high from edge t+1 onward.
  - Minimum turnaround from the last bit to accepting the next frame's first bit is 3 cycles, with out_ready held at 1.
- par_data is stable from the last-bit edge through the LOAD cycle and is not modified in LOAD or HOLD.
- load_en is never high for more than one consecutive cycle. It is never asserted for a partial or aborted frame.
- sync on a bit while in LOAD or HOLD has no effect, because sin_ready=0 and the bit is not accepted.
- Reset asserted mid-frame or in HOLD: the partial word is discarded, no load_en is issued, and out_valid drops immediately (asynchronously).
- frame_cnt wrap: 8'hFF + 1 = 8'h00, with no flag.
- All outputs are registered or decoded directly from the state register; there are no combinational paths from sin or sin_valid to outputs. The exception is sin_ready, which depends only on state.

Test Plan:
1. N=4, MSB_FIRST=1; 16 back-to-back bits of 16'hA5C3, MSB first, with sync on the first bit -> load_en high exactly 1 cycle, 1 cycle after the last bit; par_data=16'hA5C3; out_valid=1 at the next edge; frame_cnt=1.
2. Same frame with sin_valid low on alternate cycles, then out_ready held 0 for 10 cycles -> par_data=16'hA5C3; out_valid and par_data held 10 cycles; sin_ready=0 throughout; the word is consumed when out_ready=1 and sin_ready returns to 1 one cycle later.
3. 7 bits of one frame, then a new sync and 16 bits of 16'h1234 -> frame_err pulses 1 cycle; exactly one load_en; par_data=16'h1234; frame_cnt=1.
4. Bits sent with sync=0 while IDLE, then a proper frame of 16'hFFFF -> leading bits ignored; par_data=16'hFFFF; single load_en.
5. rst_n pulled low after 9 bits of a frame -> no load_en; all outputs at reset values; a following full frame of 16'h0F0F loads correctly.
6. MSB_FIRST=0, bit stream 1,0,0,...,0 (16 bits) -> par_data=16'h0001. Run 256 frames -> frame_cnt returns to 0.
